// File: rtl/huffman_bit_unpacker.sv
// Byte-to-2-bit-chunk feeder for the Huffman decoder: a small byte FIFO followed
// by a shift-register serialiser with support for a short final byte.
module huffman_bit_unpacker #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [7:0]               i_byte_in,
    input  logic                     i_byte_valid,
    input  logic                     i_byte_last,
    input  logic [1:0]               i_byte_chunks,
    output logic                     o_byte_ready,
    output logic [1:0]               o_bit_out,
    output logic                     o_valid_out,
    input  logic                     i_bit_ready,
    output logic                     o_eos_out,
    output logic [$clog2(DEPTH):0]   o_fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry layout: {last, chunks_minus_1[1:0], byte[7:0]}
    logic [10:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [7:0]    r_sh;
    logic [2:0]    r_left;
    logic          r_is_last;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_adv;
    logic          w_load;
    logic [10:0]   w_head;
    logic [2:0]    w_head_left;
    logic [7:0]    w_sh_next;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_byte_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    assign w_adv  = (r_left != 3'd0) && i_bit_ready;
    // Reloading on the last accepted chunk keeps the output stream gap-free.
    assign w_load = ((r_left == 3'd0) || ((r_left == 3'd1) && w_adv)) && !w_empty;
    assign w_pop  = w_load;

    assign w_head_left = w_head[10] ? ({1'b0, w_head[9:8]} + 3'd1) : 3'd4;
    assign w_sh_next   = MSB_FIRST ? {r_sh[5:0], 2'b00} : {2'b00, r_sh[7:2]};

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_byte_last, i_byte_chunks, i_byte_in};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh      <= '0;
            r_left    <= '0;
            r_is_last <= 1'b0;
        end else if (w_load) begin
            r_sh      <= w_head[7:0];
            r_left    <= w_head_left;
            r_is_last <= w_head[10];
        end else if (w_adv) begin
            r_sh      <= w_sh_next;
            r_left    <= r_left - 3'd1;
        end
    end

    assign o_byte_ready = !w_full;
    assign o_fill_level = r_count;
    assign o_valid_out  = (r_left != 3'd0);
    assign o_bit_out    = MSB_FIRST ? r_sh[7:6] : r_sh[1:0];
    assign o_eos_out    = r_is_last && (r_left == 3'd1);

endmodule

// File: tb/tb_huffman_bit_unpacker.sv
// Bench for huffman_bit_unpacker: an MSB-first and an LSB-first instance share
// one stimulus stream; a chunk-list model fills expected queues per instance.
module tb_huffman_bit_unpacker;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          i_reset;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_last;
    logic [1:0]    byte_chunks;
    logic          bit_ready;

    logic          m_ready, l_ready;
    logic [1:0]    m_bit, l_bit;
    logic          m_valid, l_valid;
    logic          m_eos, l_eos;
    logic [CW-1:0] m_fill, l_fill;

    logic [2:0] exp_m_q[$];
    logic [2:0] exp_l_q[$];

    int errors = 0;
    int checks = 0;
    logic       stall [2];
    logic [1:0] hold_bit [2];
    logic       hold_eos [2];
    logic       rnd_br;

    huffman_bit_unpacker #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
        .i_clk(clk), .i_reset(i_reset), .i_byte_in(byte_in), .i_byte_valid(byte_valid),
        .i_byte_last(byte_last), .i_byte_chunks(byte_chunks), .o_byte_ready(m_ready),
        .o_bit_out(m_bit), .o_valid_out(m_valid), .i_bit_ready(bit_ready),
        .o_eos_out(m_eos), .o_fill_level(m_fill)
    );

    huffman_bit_unpacker #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .i_clk(clk), .i_reset(i_reset), .i_byte_in(byte_in), .i_byte_valid(byte_valid),
        .i_byte_last(byte_last), .i_byte_chunks(byte_chunks), .o_byte_ready(l_ready),
        .o_bit_out(l_bit), .o_valid_out(l_valid), .i_bit_ready(bit_ready),
        .o_eos_out(l_eos), .o_fill_level(l_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: a byte becomes an ordered list of 2-bit fields, counted from
    // the emitting end, truncated to chunks+1 entries when it ends the stream.
    function automatic void push_exp(logic [7:0] b, logic last, logic [1:0] ch);
        int n;
        int bi;
        int mv;
        int lv;
        logic e;
        n  = last ? int'(ch) + 1 : 4;
        bi = int'(b);
        for (int k = 0; k < n; k++) begin
            mv = (bi >> (6 - 2 * k)) % 4;
            lv = (bi >> (2 * k)) % 4;
            e  = last && (k == n - 1);
            exp_m_q.push_back({e, 2'(mv)});
            exp_l_q.push_back({e, 2'(lv)});
        end
    endfunction

    task automatic send(input logic [7:0] b, input logic last, input logic [1:0] ch);
        int t;
        t = 0;
        byte_in     = b;
        byte_last   = last;
        byte_chunks = ch;
        byte_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (m_ready && !i_reset) begin
                push_exp(b, last, ch);
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 5000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_m_q.size() != 0 || exp_l_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        chk("drain_done", int'(t < 3000), 1);
        tick();
        tick();
        chk("drain_idle_valid", m_valid, 0);
    endtask

    task automatic check_out(input int w, input logic v, input logic [1:0] b, input logic e);
        logic [2:0] exp;
        string nm;
        nm = (w == 0) ? "msb" : "lsb";
        if (stall[w]) begin
            chk({nm, "_hold_valid"}, v, 1);
            chk({nm, "_hold_bits"}, b, hold_bit[w]);
            chk({nm, "_hold_eos"}, e, hold_eos[w]);
        end
        if (v && bit_ready) begin
            if ((w == 0 && exp_m_q.size() == 0) || (w == 1 && exp_l_q.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_chunk: got chunk %0d, required no output (t=%0t)", nm, b, $time);
            end else begin
                if (w == 0) exp = exp_m_q.pop_front();
                else        exp = exp_l_q.pop_front();
                chk({nm, "_chunk"}, b, exp[1:0]);
                chk({nm, "_eos"}, e, exp[2]);
            end
        end
        stall[w]    = v && !bit_ready;
        hold_bit[w] = b;
        hold_eos[w] = e;
    endtask

    always @(negedge clk) begin
        if (i_reset) begin
            exp_m_q.delete();
            exp_l_q.delete();
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            check_out(0, m_valid, m_bit, m_eos);
            check_out(1, l_valid, l_bit, l_eos);
        end
    end

    initial begin
        int mx;
        i_reset     = 1'b1;
        byte_in     = '0;
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        byte_chunks = '0;
        bit_ready   = 1'b1;
        rnd_br      = 1'b0;
        stall[0]    = 1'b0;
        stall[1]    = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;

        chk("rst_valid", m_valid, 0);
        chk("rst_bit", m_bit, 0);
        chk("rst_eos", m_eos, 0);
        chk("rst_fill", m_fill, 0);
        chk("rst_ready", m_ready, 1);
        chk("rst_valid_lsb", l_valid, 0);

        // Single byte: visible one edge after the write, for four cycles.
        send(8'hB4, 1'b0, 2'd0);
        chk("single_pre_valid", m_valid, 0);
        chk("single_fill", m_fill, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_valid", m_valid, 1);
        end
        tick();
        chk("single_done", m_valid, 0);
        chk("single_done_lsb", l_valid, 0);
        tick();

        // Back-to-back bytes: eight gap-free chunks, occupancy never above 1.
        send(8'h1B, 1'b0, 2'd0);
        mx = int'(m_fill);
        send(8'hE4, 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_valid", m_valid, 1);
            if (int'(m_fill) > mx) mx = int'(m_fill);
            tick();
        end
        chk("b2b_done", m_valid, 0);
        chk("b2b_peak_fill", mx, 1);

        // Full FIFO under back-pressure.
        bit_ready = 1'b0;
        send(8'h11, 1'b0, 2'd0);
        send(8'h22, 1'b0, 2'd0);
        send(8'h33, 1'b0, 2'd0);
        send(8'h44, 1'b0, 2'd0);
        send(8'h55, 1'b0, 2'd0);
        chk("full_fill", m_fill, DEPTH);
        chk("full_ready", m_ready, 0);
        fork
            send(8'h66, 1'b0, 2'd0);
        join_none
        repeat (3) tick();
        chk("full_still_ready", m_ready, 0);
        bit_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("full_ready_low", m_ready, 0);
        end
        tick();
        chk("full_ready_back", m_ready, 1);
        drain();

        // Short final byte, then a normal byte with no stale chunks.
        send(8'hC0, 1'b1, 2'd1);
        tick();
        chk("short_first_valid", m_valid, 1);
        chk("short_first_eos", m_eos, 0);
        tick();
        chk("short_second_valid", m_valid, 1);
        chk("short_second_eos", m_eos, 1);
        tick();
        chk("short_end_valid", m_valid, 0);
        send(8'h40, 1'b0, 2'd0);
        drain();

        // Reset after two of four chunks with two bytes queued.
        send(8'hA5, 1'b0, 2'd0);
        send(8'h5A, 1'b0, 2'd0);
        send(8'hFF, 1'b0, 2'd0);
        tick();
        chk("mid_fill_before", m_fill, 2);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_fill", m_fill, 0);
        chk("mid_rst_eos", m_eos, 0);
        chk("mid_rst_bit", m_bit, 0);
        repeat (12) tick();
        chk("mid_rst_quiet", m_valid, 0);

        // Randomised stream with random back-pressure.
        rnd_br = 1'b1;
        fork
            begin
                while (rnd_br) begin
                    tick();
                    if (rnd_br) bit_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 300; n++) begin
            send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        rnd_br = 1'b0;
        tick();
        bit_ready = 1'b1;
        drain();

        chk("final_queue_msb", exp_m_q.size(), 0);
        chk("final_queue_lsb", exp_l_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/huffman_bit_unpacker.md
# huffman_bit_unpacker

Upstream feeder for the Huffman decoder. It accepts a byte stream with a valid/ready handshake and buffers it in a small FIFO. It serialises each byte into 2-bit chunks presented on `bit_out`/`valid_out`, which connect directly to the decoder's `bit_in`/`valid_in`. An end-of-stream marker lets the final byte carry fewer than four chunks, and `eos_out` flags the last chunk emitted.

## Interface
- `DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `MSB_FIRST`, 1: 1 emits byte bits [7:6] first; 0 emits bits [1:0] first.

- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears FIFO, serialiser and all outputs.
- `byte_in` in 8: input byte.
- `byte_valid` in 1: `byte_in` valid.
- `byte_last` in 1: qualifies the byte as the final byte of the stream.
- `byte_chunks` in 2: valid chunk count minus 1 for a `byte_last` byte (0 means 1 chunk, 3 means 4 chunks); ignored when `byte_last` = 0.
- `byte_ready` out 1: FIFO can accept; equals !full.
- `bit_out` out 2: current chunk.
- `valid_out` out 1: `bit_out` is valid.
- `bit_ready` in 1: downstream accepts the chunk; tie high for the decoder.
- `eos_out` out 1: high together with `valid_out` on the last chunk of a `byte_last` byte.
- `fill_level` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.

## Operation
- **FIFO write**
  - Occurs on an edge where `byte_valid` && `byte_ready` && !`reset`.
  - Stores the tuple {`byte_in`, `byte_last`, `byte_chunks`}.
- **FIFO pointers**
  - `log2(DEPTH)`-bit read/write pointers wrap modulo DEPTH.
  - A separate count register drives full, empty and `fill_level`.
- **Serialiser**
  - Holds an 8-bit shift register `sh`, a 3-bit `left` counter (0..4) and an `is_last` flag.
  - `valid_out` = (`left` != 0).
  - `bit_out` = `sh[7:6]` (MSB_FIRST=1) or `sh[1:0]` (MSB_FIRST=0).
  - `eos_out` = `is_last` && (`left` == 1).
- **Advance condition:** `adv` = `valid_out` && `bit_ready`. On `adv`:
  - `sh` shifts by 2 toward the output end, zero-fill.
  - `left` decrements by 1.
- **Load condition:** (`left` == 0, or (`left` == 1 && `adv`)) && FIFO not empty. On load:
  - Pop the FIFO head into `sh`.
  - `left` = `byte_last` ? `byte_chunks` + 1 : 4.
  - `is_last` = `byte_last`.
  - Load takes priority over the shift on the same edge, so there is no bubble between bytes.
- **Short final byte:** for a `byte_last` byte with fewer than 4 chunks, the unused low-order chunks (MSB_FIRST=1) or high-order chunks (MSB_FIRST=0) are never emitted.
- **Simultaneous push and pop**
  - Count stays unchanged.
  - Allowed when full only if a pop occurs that edge. `byte_ready` is still low in that case, so no write is accepted.
- **Empty FIFO:** when `left` reaches 0 with an empty FIFO, `valid_out` drops. It rises again on the edge a byte is loaded.
- **Back-pressure:** while `bit_ready` = 0, `bit_out`, `valid_out` and `eos_out` hold stable.

## Timing
- **Reset values:** `valid_out` = 0, `bit_out` = 2'b00, `eos_out` = 0, `fill_level` = 0.
  - `byte_ready` = 1 from the first cycle after reset deasserts.
  - While `reset` is high, writes are ignored.
- **Latency:** a byte written at edge N into an empty FIFO with an idle serialiser is loaded at edge N+1. Its first chunk is visible with `valid_out` = 1 after edge N+1.
- **Throughput:** one chunk per cycle with `bit_ready` = 1, i.e. one byte per 4 cycles. The input side sustains a byte per cycle until full.
- **Reset mid-stream:** contents and the partially shifted byte are discarded. Outputs return to reset values on the following cycle.
- **Outputs and ready path:** all outputs are registers or decodes of registers. `byte_ready` has no combinational path from `bit_ready`.

## Test plan
- **Single byte:** reset, write 0xB4 (MSB_FIRST=1), `bit_ready` = 1 → `valid_out` for 4 consecutive cycles starting one edge after the write, `bit_out` = 2,3,1,0, then `valid_out` = 0; `eos_out` never high.
- **Back-to-back streaming:** write 0x1B, 0xE4 on consecutive cycles → 8 consecutive chunks 0,1,2,3,3,2,1,0 with no gap; `fill_level` peaks at 1.
- **Full / back-pressure:** DEPTH=4, `bit_ready` = 0, write 6 bytes → `byte_ready` falls after 4 FIFO writes plus 1 serialiser load (`fill_level` = 4). Raise `bit_ready` → `byte_ready` returns 1 on the cycle after the next pop; every chunk is emitted in order.
- **Short final byte:** write 0xC0 with `byte_last` = 1, `byte_chunks` = 1 → exactly 2 chunks 3,0; `eos_out` = 1 on the second. Then write 0x40 → it is emitted next with no stale chunks.
- **Reset mid-stream:** assert `reset` for 1 cycle after 2 of 4 chunks, with 2 bytes queued → `valid_out` = 0 and `fill_level` = 0 the next cycle, and nothing is emitted afterward.
- **LSB-first mode:** MSB_FIRST=0, write 0xB4 → chunks 0,1,3,2.
